sram_req_arbiter: RTL and testbench

- Shares one sram-like memory port between the IF-stage instruction requester and the MEM-stage data requester.
- Grants one address handshake per cycle and records the owner of each accepted request in an in-order tag FIFO.
- Routes each returning data_ok/rdata to the requester that owns the oldest outstanding transaction.
- Sits between the pipeline's inst/data sram-like ports and the memory bridge.

---
 rtl/sram_req_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_req_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one sram-like memory port between the IF-stage instruction
//   requester (inst_*) and the MEM-stage data requester (data_*).
//   One address handshake is granted per cycle. The owner of each accepted
//   request is recorded in an in-order tag FIFO. Each mem_data_ok is steered
//   to the owner of the oldest outstanding transaction.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   inst_* / data_*     requester side: req/wr/size/addr/wstrb/wdata in;
//                       addr_ok, data_ok, rdata out
//   mem_*               memory side: req/wr/size/addr/wstrb/wdata out;
//                       addr_ok, data_ok, rdata in
//   outstd_cnt          number of accepted but not yet returned transactions
//   order_err           sticky flag: mem_data_ok arrived with nothing outstanding
module sram_req_arbiter #(
  parameter int OUTSTD_DEPTH = 4,
  parameter int PTR_W        = 2,
  parameter int STARVE_LIM   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic [PTR_W:0]   outstd_cnt,
  output logic             order_err
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);

  logic [OUTSTD_DEPTH-1:0] tag_q;   // 0 = inst, 1 = data
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [SC_W-1:0]         starve_cnt;

  logic full, empty, starved, sel_inst, sel_data, accept, pop, head;

  assign full     = (outstd_cnt == (PTR_W+1)'(OUTSTD_DEPTH));
  assign empty    = (outstd_cnt == '0);
  assign starved  = (starve_cnt >= SC_W'(STARVE_LIM));

  // Data normally has priority; a starved inst request overrides it.
  assign sel_inst = inst_req & (~data_req | starved);
  assign sel_data = data_req & ~sel_inst;

  // Full blocks the request outright, even if a pop frees a slot this
  // cycle: no pop-to-push bypass path. Outputs are forced low during reset.
  assign mem_req  = ~reset & (inst_req | data_req) & ~full;
  assign accept   = mem_req & mem_addr_ok;
  assign pop      = ~reset & mem_data_ok & ~empty;
  assign head     = tag_q[rd_ptr];

  assign inst_addr_ok = accept & sel_inst;
  assign data_addr_ok = accept & sel_data;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_wr    = sel_inst ? inst_wr    : data_wr;
  assign mem_size  = sel_inst ? inst_size  : data_size;
  assign mem_addr  = sel_inst ? inst_addr  : data_addr;
  assign mem_wstrb = sel_inst ? inst_wstrb : data_wstrb;
  assign mem_wdata = sel_inst ? inst_wdata : data_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      outstd_cnt <= '0;
      starve_cnt <= '0;
      order_err  <= 1'b0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr] <= sel_data;
        wr_ptr        <= wr_ptr + 1'b1;  // wraps naturally, depth is a power of two
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({accept, pop})
        2'b10:   outstd_cnt <= outstd_cnt + 1'b1;
        2'b01:   outstd_cnt <= outstd_cnt - 1'b1;
        default: outstd_cnt <= outstd_cnt;
      endcase

      // A return with nothing outstanding is dropped and latched as an error.
      if (mem_data_ok && empty)
        order_err <= 1'b1;

      // Count waiting cycles of inst; saturate so inst keeps winning until served.
      if (inst_req && !inst_addr_ok) begin
        if (!starved)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstd_cnt;
  logic        order_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTD_DEPTH(DEPTH), .PTR_W(2), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstd_cnt(outstd_cnt), .order_err(order_err)
  );

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #3;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    @(posedge clk); #1;
    checks++;
    if (outstd_cnt !== 3'd0 || order_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state cnt=%0d err=%b exp cnt=0 err=0", outstd_cnt, order_err);
    end
    do_reset();
  endtask

  task automatic test_inst_only();
    do_reset();
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (!(mem_req === 1 && inst_addr_ok === 1 && data_addr_ok === 0 && mem_addr === 32'h1c000000)) begin
      errors++;
      $display("FAIL inst_only_grant req=%b iaok=%b daok=%b addr=%h exp 1 1 0 1c000000",
               mem_req, inst_addr_ok, data_addr_ok, mem_addr);
    end
    @(posedge clk); #1;
    inst_req = 0;
    checks++;
    if (outstd_cnt !== 3'd1) begin
      errors++; $display("FAIL inst_only_cnt1 got=%0d exp=1", outstd_cnt);
    end
    @(posedge clk); #1;
    mem_data_ok = 1; mem_rdata = 32'h02800c0c;
    @(negedge clk);
    checks++;
    if (!(inst_data_ok === 1 && data_data_ok === 0 && inst_rdata === 32'h02800c0c)) begin
      errors++;
      $display("FAIL inst_only_return idok=%b ddok=%b rdata=%h exp 1 0 02800c0c",
               inst_data_ok, data_data_ok, inst_rdata);
    end
    @(posedge clk); #1;
    mem_data_ok = 0;
    checks++;
    if (outstd_cnt !== 3'd0 || order_err !== 0) begin
      errors++; $display("FAIL inst_only_cnt0 cnt=%0d err=%b exp 0 0", outstd_cnt, order_err);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_req = 1; inst_addr = 32'h1c000000;
    data_req = 1; data_addr = 32'h1c008000; mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (!(data_addr_ok === 1 && inst_addr_ok === 0 && mem_addr === 32'h1c008000)) begin
      errors++;
      $display("FAIL simul_data_first daok=%b iaok=%b addr=%h exp 1 0 1c008000",
               data_addr_ok, inst_addr_ok, mem_addr);
    end
    @(posedge clk); #1;
    data_req = 0;
    @(negedge clk);
    checks++;
    if (!(inst_addr_ok === 1 && data_addr_ok === 0 && mem_addr === 32'h1c000000)) begin
      errors++;
      $display("FAIL simul_inst_second iaok=%b daok=%b addr=%h exp 1 0 1c000000",
               inst_addr_ok, data_addr_ok, mem_addr);
    end
    @(posedge clk); #1;
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hdddd0001;
    @(negedge clk);
    checks++;
    if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'hdddd0001) begin
      errors++;
      $display("FAIL simul_ret_D dd/id=%b rdata=%h exp 10 dddd0001",
               {data_data_ok, inst_data_ok}, data_rdata);
    end
    @(posedge clk); #1;
    mem_rdata = 32'h11110002;
    @(negedge clk);
    checks++;
    if ({data_data_ok, inst_data_ok} !== 2'b01 || inst_rdata !== 32'h11110002) begin
      errors++;
      $display("FAIL simul_ret_I dd/id=%b rdata=%h exp 01 11110002",
               {data_data_ok, inst_data_ok}, inst_rdata);
    end
    @(posedge clk); #1;
    mem_data_ok = 0;
    @(negedge clk);
    checks++;
    if ({data_data_ok, inst_data_ok} !== 2'b00 || outstd_cnt !== 3'd0) begin
      errors++;
      $display("FAIL simul_single_pulse dd/id=%b cnt=%0d exp 00 0",
               {data_data_ok, inst_data_ok}, outstd_cnt);
    end
  endtask

  task automatic test_full();
    int hs = 0;
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (inst_addr_ok === 1) hs++;
      @(posedge clk); #1;
    end
    checks++;
    if (hs != DEPTH || mem_req !== 0 || outstd_cnt !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL full_block hs=%0d req=%b cnt=%0d exp 4 0 4", hs, mem_req, outstd_cnt);
    end
    mem_data_ok = 1;
    @(negedge clk);
    checks++;
    if (mem_req !== 0 || inst_addr_ok !== 0 || inst_data_ok !== 1) begin
      errors++;
      $display("FAIL full_no_bypass req=%b iaok=%b idok=%b exp 0 0 1", mem_req, inst_addr_ok, inst_data_ok);
    end
    @(posedge clk); #1;
    mem_data_ok = 0;
    checks++;
    if (outstd_cnt !== 3'd3 || mem_req !== 1) begin
      errors++;
      $display("FAIL full_reassert cnt=%0d req=%b exp 3 1", outstd_cnt, mem_req);
    end
  endtask

  task automatic test_starvation();
    int first = -1;
    do_reset();
    inst_req = 1; inst_addr = 32'h1c000100;
    data_req = 1; data_addr = 32'h1c008100;
    mem_addr_ok = 1; mem_data_ok = 0;
    for (int c = 1; c <= 12 && first < 0; c++) begin
      // keep the FIFO from filling: one return per cycle once something is outstanding
      mem_data_ok = (outstd_cnt != 0);
      @(negedge clk);
      if (inst_addr_ok === 1) first = c;
      @(posedge clk); #1;
    end
    checks++;
    if (first != LIM + 1) begin
      errors++;
      $display("FAIL starve_grant_cycle got=%0d exp=%0d", first, LIM + 1);
    end
    // counter cleared: with both still requesting, data wins again
    mem_data_ok = (outstd_cnt != 0);
    @(negedge clk);
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL starve_cleared ia/da=%b exp 01", {inst_addr_ok, data_addr_ok});
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_interleave();
    do_reset();
    mem_addr_ok = 1;
    inst_req = 1;
    @(posedge clk); #1;
    inst_req = 0; data_req = 1;
    @(posedge clk); #1;
    // at cnt 2: push (data) and pop (inst head) together
    mem_data_ok = 1;
    @(negedge clk);
    checks++;
    if (!(outstd_cnt === 3'd2 && data_addr_ok === 1 && inst_data_ok === 1)) begin
      errors++;
      $display("FAIL interleave_pre cnt=%0d daok=%b idok=%b exp 2 1 1", outstd_cnt, data_addr_ok, inst_data_ok);
    end
    @(posedge clk); #1;
    data_req = 0; mem_data_ok = 0;
    checks++;
    if (outstd_cnt !== 3'd2) begin
      errors++; $display("FAIL interleave_cnt_hold got=%0d exp=2", outstd_cnt);
    end
  endtask

  // Randomized traffic against a queue-based model of the owner FIFO.
  task automatic test_random();
    bit q[$];
    int starve = 0;
    bit err = 0;
    int pushes = 0;
    bit ir, dr, maok, mdok, full, emr, esi, acc, eia, eda, eid, edd;
    logic [70:0] exp_f, got_f;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ir = ($urandom_range(0, 3) != 0); dr = ($urandom_range(0, 2) == 0);
      maok = ($urandom_range(0, 9) < 7);
      mdok = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 40) == 0);
      inst_req = ir; data_req = dr; mem_addr_ok = maok; mem_data_ok = mdok;
      inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_addr = $urandom;
      inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom;
      data_wstrb = 4'($urandom); data_wdata = $urandom;
      mem_rdata = $urandom;

      full = (q.size() == DEPTH);
      emr  = (ir || dr) && !full;
      esi  = ir && (!dr || starve >= LIM);
      acc  = emr && maok;
      eia  = acc && esi;
      eda  = acc && !esi;
      eid  = mdok && q.size() > 0 && q[0] == 0;
      edd  = mdok && q.size() > 0 && q[0] == 1;

      @(negedge clk);
      checks++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {emr, eia, eda, eid, edd}) begin
        errors++;
        $display("FAIL rand_hs n=%0d req/ia/da/id/dd got=%b exp=%b", n,
                 {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                 {emr, eia, eda, eid, edd});
      end
      if (emr) begin
        exp_f = esi ? {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata}
                    : {data_wr, data_size, data_addr, data_wstrb, data_wdata};
        got_f = {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata};
        checks++;
        if (got_f !== exp_f) begin
          errors++; $display("FAIL rand_fields n=%0d got=%h exp=%h", n, got_f, exp_f);
        end
      end
      if (mdok) begin
        checks++;
        if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
          errors++;
          $display("FAIL rand_rdata n=%0d i=%h d=%h exp=%h", n, inst_rdata, data_rdata, mem_rdata);
        end
      end

      if (mdok) begin
        if (q.size() > 0) void'(q.pop_front());
        else err = 1;
      end
      if (acc) begin q.push_back(!esi); pushes++; end
      starve = (ir && !eia) ? ((starve + 1 > LIM) ? LIM : starve + 1) : 0;

      @(posedge clk); #1;
      checks++;
      if (outstd_cnt !== 3'(q.size()) || order_err !== err) begin
        errors++;
        $display("FAIL rand_state n=%0d cnt=%0d err=%b exp %0d %b", n, outstd_cnt, order_err, q.size(), err);
      end
    end
    checks++;
    if (pushes < 10) begin
      errors++; $display("FAIL rand_coverage pushes=%0d exp>=10", pushes);
    end
    clear_inputs();
  endtask

  task automatic test_error_reset();
    do_reset();
    mem_data_ok = 1;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL err_no_dataok got=%b exp=00", {inst_data_ok, data_data_ok});
    end
    @(posedge clk); #1;
    mem_data_ok = 0;
    checks++;
    if (order_err !== 1 || outstd_cnt !== 0) begin
      errors++; $display("FAIL err_sticky err=%b cnt=%0d exp 1 0", order_err, outstd_cnt);
    end
    inst_req = 1; mem_addr_ok = 1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (order_err !== 1 || outstd_cnt !== 3'd2) begin
      errors++; $display("FAIL err_burst err=%b cnt=%0d exp 1 2", order_err, outstd_cnt);
    end
    // reset mid-cycle, away from any clock edge
    #2;
    mem_data_ok = 1;
    reset = 1;
    #1;
    checks++;
    if ({order_err, outstd_cnt, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 8'b0) begin
      errors++;
      $display("FAIL err_async_reset err=%b cnt=%0d req=%b ia=%b da=%b id=%b dd=%b exp all 0",
               order_err, outstd_cnt, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
    end
    @(posedge clk); #1;
    clear_inputs();
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_inst_only();
    test_simultaneous();
    test_full();
    test_starvation();
    test_interleave();
    test_random();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
